// File: rtl/dot_accel_pkg.sv
// dot_accel_pkg: register map, control/status bit indices, sequencer states and byte-merge helper
package dot_accel_pkg;
  localparam logic [9:0] CTRL_OFF   = 10'h000;
  localparam logic [9:0] STATUS_OFF = 10'h004;
  localparam logic [9:0] LEN_OFF    = 10'h008;
  localparam logic [9:0] RESULT_OFF = 10'h00C;
  localparam logic [9:0] A_BASE     = 10'h100;
  localparam logic [9:0] B_BASE     = 10'h200;
  localparam int CTRL_START  = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_SAT  = 3;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    for (int k = 0; k < 4; k++) merge_bytes[8*k+:8] = strb[k] ? new_v[8*k+:8] : old_v[8*k+:8];
  endfunction
endpackage

// File: rtl/dot_accel_mmio_dot4.sv
// dot4_int8: four-lane signed int8 multiply-add, 18-bit signed sum
module dot4_int8 (
  input  logic        [31:0] a_i,
  input  logic        [31:0] b_i,
  output logic signed [17:0] sum_o
);
  logic signed [15:0] p [4];
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign p[k] = 16'($signed(a_i[8*k+:8])) * 16'($signed(b_i[8*k+:8]));
  end
  assign sum_o = 18'(p[0]) + 18'(p[1]) + 18'(p[2]) + 18'(p[3]);
endmodule

// File: rtl/dot_accel_mmio.sv
// dot_accel_mmio: MMIO signed int8 dot-product accelerator; define DOT_ACCEL_SAT_EN for saturating accumulation
module dot_accel_mmio
  import dot_accel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [9:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] bus_rdata,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic ready_q;
  logic [31:0] rdata_q, rd_val, status, ctrl, len_w, result_q;
  logic [9:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic [8:0] len_q, idx_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic done_q, err_q, irq_en_q, sat_q, clamp;
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic req, wr, busy, wr_ctrl, wr_len, wr_a, wr_b, start, clr, len_ok, last, go, mac, fin;
  logic signed [17:0] dot_w;
  logic signed [33:0] sum_w;
  logic unused_ok;
  assign req     = bus_sel & bus_valid & ~ready_q;
  assign wr      = ready_q & (|wstrb_q);
  assign busy    = state_q != IDLE;
  assign wr_ctrl = wr & wstrb_q[0] & (addr_q == CTRL_OFF[9:2]);
  assign wr_len  = wr & ~busy & (addr_q == LEN_OFF[9:2]);
  assign wr_a    = wr & ~busy & (addr_q[9:8] == A_BASE[9:8]);
  assign wr_b    = wr & ~busy & (addr_q[9:8] == B_BASE[9:8]);
  assign start   = wr_ctrl & wdata_q[CTRL_START] & ~busy;
  assign clr     = wr_ctrl & wdata_q[CTRL_CLR];
  assign len_ok  = (len_q != '0) & (len_q <= 9'(DEPTH));
  assign last    = idx_q == len_q - 9'd1;
  assign len_w   = merge_bytes({23'b0, len_q}, wdata_q, wstrb_q);
  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign irq       = done_q & irq_en_q;
  assign unused_ok = ^{bus_addr[1:0], len_w[31:9], sum_w};
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && start && len_ok) ? RUN :
              (state_q == RUN && last)             ? FIN :
              (state_q == FIN)                     ? IDLE : state_q;
  end
  always_comb begin
    go  = state_q == IDLE && start && len_ok;
    mac = state_q == RUN;
    fin = state_q == FIN;
  end
  dot4_int8 u_dot (
    .a_i  (mem_a[idx_q[AW-1:0]]),
    .b_i  (mem_b[idx_q[AW-1:0]]),
    .sum_o(dot_w)
  );
  assign sum_w = 34'($signed(acc_q)) + 34'(dot_w);
`ifdef DOT_ACCEL_SAT_EN
  localparam logic signed [33:0] MAXV = (34'sd1 <<< (ACC_W - 1)) - 34'sd1;
  localparam logic signed [33:0] MINV = -(34'sd1 <<< (ACC_W - 1));
  always_comb begin
    clamp = (sum_w > MAXV) | (sum_w < MINV);
    acc_d = (sum_w > MAXV) ? MAXV[ACC_W-1:0] : (sum_w < MINV) ? MINV[ACC_W-1:0] : sum_w[ACC_W-1:0];
  end
`else
  assign clamp = 1'b0;
  assign acc_d = sum_w[ACC_W-1:0];
`endif
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
    status[ST_SAT]  = sat_q;
    ctrl = '0;
    ctrl[CTRL_IRQ_EN] = irq_en_q;
    rd_val = (bus_addr[9:8] == A_BASE[9:8])     ? mem_a[bus_addr[2+:AW]] :
             (bus_addr[9:8] == B_BASE[9:8])     ? mem_b[bus_addr[2+:AW]] :
             (bus_addr[9:2] == CTRL_OFF[9:2])   ? ctrl :
             (bus_addr[9:2] == STATUS_OFF[9:2]) ? status :
             (bus_addr[9:2] == LEN_OFF[9:2])    ? {23'b0, len_q} :
             (bus_addr[9:2] == RESULT_OFF[9:2]) ? result_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      ready_q  <= req;
      rdata_q  <= req ? rd_val : '0;
      addr_q   <= req ? bus_addr[9:2] : addr_q;
      wdata_q  <= req ? bus_wdata : wdata_q;
      wstrb_q  <= req ? bus_wstrb : wstrb_q;
      len_q    <= wr_len ? len_w[8:0] : len_q;
      irq_en_q <= wr_ctrl ? wdata_q[CTRL_IRQ_EN] : irq_en_q;
      idx_q    <= go ? '0 : mac ? idx_q + 9'd1 : idx_q;
      acc_q    <= go ? '0 : mac ? acc_d : acc_q;
      result_q <= fin ? 32'($signed(acc_q)) : result_q;
      done_q   <= fin | (done_q & ~clr & ~start);
      err_q    <= start ? ~len_ok : err_q;
      sat_q    <= start ? 1'b0 : (mac & clamp) ? 1'b1 : sat_q;
    end
  end
  // operand buffers are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_a) mem_a[addr_q[2+:AW]] <= merge_bytes(mem_a[addr_q[2+:AW]], wdata_q, wstrb_q);
    if (wr_b) mem_b[addr_q[2+:AW]] <= merge_bytes(mem_b[addr_q[2+:AW]], wdata_q, wstrb_q);
  end
endmodule
